vga_scan_controller: RTL and testbench

//  Sequences the VGA raster: runs the horizontal and vertical pixel counters and decodes sync/blank phases.

---
 rtl/vga_scan_controller_pkg.sv | 43 ++++
 rtl/vga_scan_controller_if.sv | 28 ++
 rtl/vga_scan_controller_seq.sv | 56 +++++
 rtl/vga_scan_controller.sv | 130 +++++++++++++
 tb/tb_vga_scan_controller.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_scan_controller_pkg.sv
// Shared types, default 640x480@60 timing and the axis phase decoder for the VGA scan controller.
package vga_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_H_ACTIVE        = 640;
  localparam int DEF_H_FP            = 16;
  localparam int DEF_H_SYNC          = 96;
  localparam int DEF_H_BP            = 48;
  localparam int DEF_V_ACTIVE        = 480;
  localparam int DEF_V_FP            = 10;
  localparam int DEF_V_SYNC          = 2;
  localparam int DEF_V_BP            = 33;
  localparam int DEF_CW              = 16;
  localparam bit DEF_SYNC_ACTIVE_LOW = 1'b1;

  function automatic phase_t phase_of(input int unsigned c, input int unsigned act,
                                      input int unsigned fp, input int unsigned sync);
    phase_t p;
    if (c < act) begin
      p = ACTIVE;
    end else if (c < act + fp) begin
      p = FRONT;
    end else if (c < act + fp + sync) begin
      p = SYNC;
    end else begin
      p = BACK;
    end
    return p;
  endfunction

endpackage

// File: rtl/vga_scan_controller_if.sv
// Control and raster-timing bundle between the scan controller and the pixel pipeline.
interface vga_scan_controller_if #(parameter int CW = 16);
  import vga_pkg::*;

  logic          enable;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic          line_start;
  logic          frame_start;
  phase_t        h_phase;
  phase_t        v_phase;
  logic          running;

  modport master (
    output enable,
    input  pixel_x, pixel_y, hsync, vsync, video_on, line_start, frame_start,
    input  h_phase, v_phase, running
  );

  modport slave (
    input  enable,
    output pixel_x, pixel_y, hsync, vsync, video_on, line_start, frame_start,
    output h_phase, v_phase, running
  );
endinterface

// File: rtl/vga_scan_controller_seq.sv
// One raster axis: a wrapping counter plus its phase decode, exposing both current and next values
// so the parent can register decodes in step with the count.
module vga_axis_sequencer #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CW     = 16
) (
  input  logic            clk_25MHz,
  input  logic            rst,
  input  logic            clear,
  input  logic            advance,
  output logic [CW-1:0]   count,
  output logic [CW-1:0]   next_count,
  output vga_pkg::phase_t phase,
  output vga_pkg::phase_t next_phase,
  output logic            at_last
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  vga_pkg::phase_t phase_q;
  vga_pkg::phase_t phase_d;

  always_comb begin
    at_last = (count_q == CW'(TOTAL - 1));
    count_d = count_q;
    if (clear) begin
      count_d = {CW{1'b0}};
    end else if (advance) begin
      count_d = at_last ? {CW{1'b0}} : count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
    phase_d = vga_pkg::phase_of(32'(count_d), ACTIVE, FP, SYNC);
  end

  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      count_q <= {CW{1'b0}};
      phase_q <= vga_pkg::ACTIVE;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count      = count_q;
  assign next_count = count_d;
  assign phase      = phase_q;
  assign next_phase = phase_d;

endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster sequencer: start/stop FSM on frame boundaries, H/V axis counters, and registered
// sync/blank/pulse outputs decoded from next-count values so they line up with pixel_x/pixel_y.
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter bit SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW,
  parameter int CW              = DEF_CW
) (
  input  logic                  clk_25MHz,
  input  logic                  rst,
  vga_scan_controller_if.slave  bus
);

  localparam logic SYNC_ON = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;

  state_t        state_q, state_d;
  logic          running_q, running_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  logic [CW-1:0] h_count, h_next, v_count, v_next;
  phase_t        h_phase, h_next_phase, v_phase, v_next_phase;
  logic          h_last, v_last;
  logic          frame_last, seq_clear, v_advance;

  assign frame_last = h_last & v_last;
  assign seq_clear  = ~running_d;
  assign v_advance  = running_q & h_last;

  vga_axis_sequencer #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
  ) u_h_axis (
    .clk_25MHz (clk_25MHz),
    .rst       (rst),
    .clear     (seq_clear),
    .advance   (running_q),
    .count     (h_count),
    .next_count(h_next),
    .phase     (h_phase),
    .next_phase(h_next_phase),
    .at_last   (h_last)
  );

  vga_axis_sequencer #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
  ) u_v_axis (
    .clk_25MHz (clk_25MHz),
    .rst       (rst),
    .clear     (seq_clear),
    .advance   (v_advance),
    .count     (v_count),
    .next_count(v_next),
    .phase     (v_phase),
    .next_phase(v_next_phase),
    .at_last   (v_last)
  );

  // A stop request seen on the very last pixel ends the frame right there instead of draining another.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.enable) state_d = RUN;
        else            state_d = IDLE;
      end
      RUN: begin
        if (!bus.enable) state_d = frame_last ? IDLE : DRAIN;
        else             state_d = RUN;
      end
      DRAIN: begin
        if (bus.enable)      state_d = RUN;
        else if (frame_last) state_d = IDLE;
        else                 state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d != IDLE);
  end

  always_comb begin
    hsync_d       = (running_d && (h_next_phase == SYNC)) ? SYNC_ON : ~SYNC_ON;
    vsync_d       = (running_d && (v_next_phase == SYNC)) ? SYNC_ON : ~SYNC_ON;
    video_on_d    = running_d && (h_next_phase == ACTIVE) && (v_next_phase == ACTIVE);
    line_start_d  = running_d && (h_next == {CW{1'b0}});
    frame_start_d = line_start_d && (v_next == {CW{1'b0}});
  end

  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      running_q     <= 1'b0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      running_q     <= running_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.pixel_x     = h_count;
  assign bus.pixel_y     = v_count;
  assign bus.h_phase     = h_phase;
  assign bus.v_phase     = v_phase;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.video_on    = video_on_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.running     = running_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: default-timing instance for line-level timing and reset,
// reduced-timing instance for whole-frame start/stop behaviour, both checked against a closed-form model.
module tb_vga_scan_controller;
  import vga_pkg::*;

  localparam int CW   = 16;
  localparam int D_HA = 640, D_HF = 16, D_HS = 96, D_HB = 48;
  localparam int D_VA = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
  localparam int S_HA = 8,   S_HF = 2,  S_HS = 3,  S_HB = 2;
  localparam int S_VA = 6,   S_VF = 2,  S_VS = 2,  S_VB = 3;
  localparam int S_FR = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  hp;
    logic [1:0]  vp;
    logic        hs;
    logic        vs;
    logic        vid;
    logic        ls;
    logic        fs;
    logic        run;
  } snap_t;

  logic  clk_25MHz = 1'b0;
  logic  rst       = 1'b1;
  int    n_checks  = 0;
  int    n_fail    = 0;
  snap_t exp_q[$];

  vga_scan_controller_if #(.CW(CW)) bus_d ();
  vga_scan_controller_if #(.CW(CW)) bus_s ();

  vga_scan_controller u_dut (
    .clk_25MHz(clk_25MHz),
    .rst      (rst),
    .bus      (bus_d)
  );

  vga_scan_controller #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .SYNC_ACTIVE_LOW(1'b1), .CW(CW)
  ) u_small (
    .clk_25MHz(clk_25MHz),
    .rst      (rst),
    .bus      (bus_s)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  // Expected outputs t cycles after the first frame_start of a run (t=0 is that cycle).
  function automatic snap_t model(input int t, input bit run, input int ha, input int hf,
                                  input int hs, input int hb, input int va, input int vf,
                                  input int vs, input int vb);
    snap_t s;
    int ht, vt, x, y;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    s = '0;
    s.hs = 1'b1;
    s.vs = 1'b1;
    if (run) begin
      x = t % ht;
      y = (t / ht) % vt;
      s.x   = 16'(x);
      s.y   = 16'(y);
      s.hp  = (x < ha) ? 2'd0 : (x < ha + hf) ? 2'd1 : (x < ha + hf + hs) ? 2'd2 : 2'd3;
      s.vp  = (y < va) ? 2'd0 : (y < va + vf) ? 2'd1 : (y < va + vf + vs) ? 2'd2 : 2'd3;
      s.hs  = (x >= ha + hf && x < ha + hf + hs) ? 1'b0 : 1'b1;
      s.vs  = (y >= va + vf && y < va + vf + vs) ? 1'b0 : 1'b1;
      s.vid = (x < ha) && (y < va);
      s.ls  = (x == 0);
      s.fs  = (x == 0) && (y == 0);
      s.run = 1'b1;
    end
    return s;
  endfunction

  function automatic snap_t model_d(input int t, input bit run);
    return model(t, run, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB);
  endfunction

  function automatic snap_t model_s(input int t, input bit run);
    return model(t, run, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB);
  endfunction

  function automatic snap_t snap_d();
    snap_t s;
    s.x = bus_d.pixel_x;  s.y = bus_d.pixel_y;
    s.hp = bus_d.h_phase; s.vp = bus_d.v_phase;
    s.hs = bus_d.hsync;   s.vs = bus_d.vsync;
    s.vid = bus_d.video_on; s.ls = bus_d.line_start;
    s.fs = bus_d.frame_start; s.run = bus_d.running;
    return s;
  endfunction

  function automatic snap_t snap_s();
    snap_t s;
    s.x = bus_s.pixel_x;  s.y = bus_s.pixel_y;
    s.hp = bus_s.h_phase; s.vp = bus_s.v_phase;
    s.hs = bus_s.hsync;   s.vs = bus_s.vsync;
    s.vid = bus_s.video_on; s.ls = bus_s.line_start;
    s.fs = bus_s.frame_start; s.run = bus_s.running;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk_25MHz);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_d.enable = 1'b0;
    bus_s.enable = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    snap_t got, exp;
    rst = 1'b1;
    bus_d.enable = 1'b0;
    bus_s.enable = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (100) tick();
    exp = model_d(0, 1'b0);
    got = snap_d();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_idle_default got=%h exp=%h", got, exp);
    end
    exp = model_s(0, 1'b0);
    got = snap_s();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_idle_small got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_line_timing();
    snap_t got, exp;
    int hs_low, vid_n;
    hs_low = 0;
    vid_n  = 0;
    do_reset();
    bus_d.enable = 1'b1;
    for (int t = 0; t <= 1700; t++) begin
      exp_q.push_back(model_d(t, 1'b1));
      tick();
      got = snap_d();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL line_timing t=%0d got=%h exp=%h", t, got, exp);
      end
      if (t < 800 && got.hs == 1'b0) hs_low++;
      if (t < 800 && got.vid == 1'b1) vid_n++;
    end
    n_checks++;
    if (hs_low !== 96) begin
      n_fail++;
      $display("FAIL hsync_width got=%0d exp=96", hs_low);
    end
    n_checks++;
    if (vid_n !== 640) begin
      n_fail++;
      $display("FAIL line_video_on got=%0d exp=640", vid_n);
    end
  endtask

  task automatic test_frame();
    snap_t got, exp;
    int vid_n, fs_n;
    vid_n = 0;
    fs_n  = 0;
    do_reset();
    bus_s.enable = 1'b1;
    for (int t = 0; t <= 2 * S_FR; t++) begin
      exp_q.push_back(model_s(t, 1'b1));
      tick();
      got = snap_s();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL frame t=%0d got=%h exp=%h", t, got, exp);
      end
      if (t < S_FR && got.vid == 1'b1) vid_n++;
      if (got.fs == 1'b1) fs_n++;
    end
    n_checks++;
    if (vid_n !== S_HA * S_VA) begin
      n_fail++;
      $display("FAIL frame_video_on got=%0d exp=%0d", vid_n, S_HA * S_VA);
    end
    n_checks++;
    if (fs_n !== 3) begin
      n_fail++;
      $display("FAIL frame_start_count got=%0d exp=3", fs_n);
    end
  endtask

  task automatic test_drain();
    snap_t got, exp;
    do_reset();
    bus_s.enable = 1'b1;
    for (int t = 0; t <= S_FR + 20; t++) begin
      exp_q.push_back(model_s(t, t < S_FR));
      tick();
      got = snap_s();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL drain t=%0d got=%h exp=%h", t, got, exp);
      end
      if (t == 20) bus_s.enable = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    snap_t got, exp;
    int fs_n;
    fs_n = 0;
    do_reset();
    bus_s.enable = 1'b1;
    for (int t = 0; t <= 2 * S_FR + 5; t++) begin
      exp_q.push_back(model_s(t, 1'b1));
      tick();
      got = snap_s();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL resume t=%0d got=%h exp=%h", t, got, exp);
      end
      if (got.fs == 1'b1) fs_n++;
      if (t == 20)  bus_s.enable = 1'b0;
      if (t == 100) bus_s.enable = 1'b1;
    end
    n_checks++;
    if (fs_n !== 3) begin
      n_fail++;
      $display("FAIL resume_frame_starts got=%0d exp=3", fs_n);
    end
  endtask

  // Enable toggled right at the frame boundary: resume on the last pixel, then stop on the next one.
  task automatic test_boundary();
    snap_t got, exp;
    do_reset();
    bus_s.enable = 1'b1;
    for (int t = 0; t <= 2 * S_FR + 10; t++) begin
      exp_q.push_back(model_s(t, t < 2 * S_FR));
      tick();
      got = snap_s();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL boundary t=%0d got=%h exp=%h", t, got, exp);
      end
      if (t == S_FR - 2)     bus_s.enable = 1'b0;
      if (t == S_FR - 1)     bus_s.enable = 1'b1;
      if (t == 2 * S_FR - 2) bus_s.enable = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    snap_t got, exp;
    do_reset();
    bus_d.enable = 1'b1;
    for (int t = 0; t <= 700; t++) begin
      exp_q.push_back(model_d(t, 1'b1));
      tick();
      got = snap_d();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL pre_reset t=%0d got=%h exp=%h", t, got, exp);
      end
    end
    #5;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus_d.pixel_x !== 16'd0) begin
      n_fail++;
      $display("FAIL async_rst_x got=%0d exp=0", bus_d.pixel_x);
    end
    n_checks++;
    if (bus_d.hsync !== 1'b1) begin
      n_fail++;
      $display("FAIL async_rst_hsync got=%b exp=1", bus_d.hsync);
    end
    n_checks++;
    if (bus_d.running !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst_running got=%b exp=0", bus_d.running);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus_d.frame_start !== 1'b1 || bus_d.pixel_x !== 16'd0 || bus_d.running !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_after_rst got fs=%b x=%0d run=%b exp fs=1 x=0 run=1",
               bus_d.frame_start, bus_d.pixel_x, bus_d.running);
    end
  endtask

  initial begin
    bus_d.enable = 1'b0;
    bus_s.enable = 1'b0;
    test_reset();
    test_line_timing();
    test_frame();
    test_drain();
    test_back_to_back();
    test_boundary();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
